// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: four-writer round-robin arbiter with a shared 8-deep FIFO.
// Optional FIFO_ARB_FAIR_EN macro: reads and writes alternate when both are eligible.
//------------------------------------------------------------------------------
// Module   : fifo_rr_arbiter
// Desc     : Round-robin write arbitration, read issue and occupancy tracking
//            for a shared FIFO, with sticky halt on FIFO error.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] wdata2,
  input  logic [7:0] wdata3,
  input  logic       rd_req,
  input  logic       fifo_error,
  output logic [3:0] grant,
  output logic       fifo_wen,
  output logic       fifo_ren,
  output logic [7:0] fifo_din,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       halted
);

  localparam logic [3:0] DEPTH = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic       last_rd, last_rd_nxt;
  logic [3:0] grant_nxt;
  logic       wen_nxt, ren_nxt;
  logic [7:0] din_nxt;
  logic [3:0] count_nxt;

  logic [7:0] wdata_arr [4];
  logic [1:0] win;
  logic       win_vld;
  logic [1:0] idx;
  logic       rd_ok, wr_ok, pick_rd, pick_wr;

  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;
  assign wdata_arr[2] = wdata2;
  assign wdata_arr[3] = wdata3;

  // Scan from the farthest candidate back to ptr so the nearest set bit wins.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign rd_ok = rd_req && (count != 4'd0);
  assign wr_ok = win_vld && (count != DEPTH);

`ifdef FIFO_ARB_FAIR_EN
  assign pick_rd = rd_ok && !(wr_ok && last_rd);
`else
  assign pick_rd = rd_ok;
`endif
  assign pick_wr = wr_ok && !pick_rd;

  always_comb begin
    state_nxt   = IDLE;
    grant_nxt   = 4'd0;
    wen_nxt     = 1'b0;
    ren_nxt     = 1'b0;
    din_nxt     = fifo_din;
    count_nxt   = count;
    ptr_nxt     = ptr;
    last_rd_nxt = last_rd;
    if (state == HALT) begin
      state_nxt = HALT;
    end else if (fifo_error) begin
      state_nxt = HALT;
    end else if (pick_rd) begin
      state_nxt   = RD;
      ren_nxt     = 1'b1;
      count_nxt   = count - 4'd1;
      last_rd_nxt = 1'b1;
    end else if (pick_wr) begin
      state_nxt   = WR;
      grant_nxt   = 4'd1 << win;
      wen_nxt     = 1'b1;
      din_nxt     = wdata_arr[win];
      count_nxt   = count + 4'd1;
      ptr_nxt     = win + 2'd1;
      last_rd_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      last_rd  <= 1'b0;
      grant    <= 4'd0;
      fifo_wen <= 1'b0;
      fifo_ren <= 1'b0;
      fifo_din <= 8'd0;
      count    <= 4'd0;
      full     <= 1'b0;
      empty    <= 1'b1;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      last_rd  <= last_rd_nxt;
      grant    <= grant_nxt;
      fifo_wen <= wen_nxt;
      fifo_ren <= ren_nxt;
      fifo_din <= din_nxt;
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH);
      empty    <= (count_nxt == 4'd0);
      halted   <= (state_nxt == HALT);
    end
  end

endmodule

`default_nettype wire
